rv_alu_mdu: RTL and testbench

- Parametrised next-generation integer ALU for the core: XLEN-wide base ALU ops plus the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits in the execute stage, with valid/ready handshakes on input and output.
- Base ops complete in one cycle; multiply and divide run in an iterative radix-2 unit.
- A flush input lets the pipeline abandon an in-flight op on branch mispredict or trap.

---
 rtl/rv_alu_mdu_if.sv | 42 ++++
 rtl/rv_alu_mdu.sv | 218 +++++++++++++++++++++
 tb/tb_rv_alu_mdu.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_alu_mdu_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rv_alu_mdu_if
// Purpose  : Execute-stage handshake bundle for rv_alu_mdu. Carries the issue
//            side (flush, valid/ready, op, operand selects and values) and
//            the result side (valid/ready, result, busy).
// Modports : master - the pipeline issuing ops and consuming results
//            slave  - the ALU/MDU
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface rv_alu_mdu_if #(
   parameter int XLEN = 32
);
   logic            flush_in;
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      op_in;
   logic            sub_sra_in;
   logic            src1_in;
   logic            src2_in;
   logic [XLEN-1:0] pc_in;
   logic [XLEN-1:0] rs1_value_in;
   logic [XLEN-1:0] rs2_value_in;
   logic [XLEN-1:0] imm_in;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result_out;
   logic            busy_out;

   modport master (
      output flush_in, in_valid, op_in, sub_sra_in, src1_in, src2_in,
             pc_in, rs1_value_in, rs2_value_in, imm_in, out_ready,
      input  in_ready, out_valid, result_out, busy_out
   );

   modport slave (
      input  flush_in, in_valid, op_in, sub_sra_in, src1_in, src2_in,
             pc_in, rs1_value_in, rs2_value_in, imm_in, out_ready,
      output in_ready, out_valid, result_out, busy_out
   );
endinterface
`default_nettype wire

// File: rtl/rv_alu_mdu.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rv_alu_mdu
// Purpose  : XLEN-wide integer ALU plus RV M-extension. Base ops finish in one
//            cycle; MUL*/DIV*/REM* use a shared iterative radix-2 datapath
//            (shift-add multiply, restoring divide on magnitudes with a sign
//            fix-up at completion).
// Ports    : clk      - clock
//            reset_n  - asynchronous active-low reset
//            bus      - rv_alu_mdu_if.slave (issue/result handshakes, flush)
// Options  : RV_ALU_MDU_FAST_MUL_EN - when defined, MUL ops use a single-cycle
//            combinational multiplier and complete like base ops.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rv_alu_mdu #(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   rv_alu_mdu_if.slave  bus
);
   localparam int SHW = $clog2(XLEN);
   localparam int CW  = SHW + 1;
   localparam logic [CW-1:0]   C_ITER = CW'(XLEN);
   localparam logic [CW-1:0]   C_LAST = CW'(1);
   localparam logic [XLEN-1:0] C_ONES = '1;
   localparam logic [XLEN-1:0] C_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [4:0] OP_ADD_SUB = 5'd0;
   localparam logic [4:0] OP_XOR     = 5'd1;
   localparam logic [4:0] OP_OR      = 5'd2;
   localparam logic [4:0] OP_AND     = 5'd3;
   localparam logic [4:0] OP_SLL     = 5'd4;
   localparam logic [4:0] OP_SRL_SRA = 5'd5;
   localparam logic [4:0] OP_SLT     = 5'd6;
   localparam logic [4:0] OP_SLTU    = 5'd7;
   localparam logic [4:0] OP_SRC1P4  = 5'd8;
   localparam logic [4:0] OP_SRC2    = 5'd9;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] acc_hi;     // product high half / partial remainder
   logic [XLEN-1:0] acc_lo;     // multiplier bits / dividend-quotient bits
   logic [XLEN-1:0] opnd_b;     // multiplicand / divisor magnitude
   logic [XLEN-1:0] result_r;
   logic            neg_res;
   logic            take_hi;
   logic            out_valid_r;
   logic            busy_r;

   // ---------------- operand selection and base ALU ----------------
   logic [XLEN-1:0]        s1, s2;
   logic signed [XLEN-1:0] s1_sgn;
   logic [XLEN:0]          diff;
   logic [SHW-1:0]         shamt;
   logic                   lt_s;
   logic [XLEN-1:0]        alu_res;

   assign s1     = bus.src1_in ? bus.pc_in  : bus.rs1_value_in;
   assign s2     = bus.src2_in ? bus.imm_in : bus.rs2_value_in;
   assign s1_sgn = s1;
   assign diff   = {1'b0, s1} - {1'b0, s2};
   assign shamt  = s2[SHW-1:0];
   // Same signs: the borrow decides; different signs: the negative one is less.
   assign lt_s   = (s1[XLEN-1] != s2[XLEN-1]) ? s1[XLEN-1] : diff[XLEN];

   always_comb begin
      alu_res = '0;
      case (bus.op_in)
         OP_ADD_SUB: alu_res = bus.sub_sra_in ? diff[XLEN-1:0] : s1 + s2;
         OP_XOR:     alu_res = s1 ^ s2;
         OP_OR:      alu_res = s1 | s2;
         OP_AND:     alu_res = s1 & s2;
         OP_SLL:     alu_res = s1 << shamt;
         OP_SRL_SRA: alu_res = bus.sub_sra_in ? XLEN'(s1_sgn >>> shamt) : s1 >> shamt;
         OP_SLT:     alu_res = {{(XLEN-1){1'b0}}, lt_s};
         OP_SLTU:    alu_res = {{(XLEN-1){1'b0}}, diff[XLEN]};
         OP_SRC1P4:  alu_res = s1 + XLEN'(4);
         OP_SRC2:    alu_res = s2;
         default:    alu_res = '0;
      endcase
   end

   // ---------------- M-extension decode ----------------
   logic            is_mul, is_div, a_signed, b_signed, sa, sb;
   logic            take_hi_w, neg_w, div_zero, div_ovf, start_iter;
   logic [XLEN-1:0] mag_a, mag_b, div_quick, quick_res;

   assign is_mul    = (bus.op_in[4:2] == 3'b100);
   assign is_div    = (bus.op_in[4:2] == 3'b101);
   // MUL/MULH/MULHSU: src1 signed; MUL/MULH: src2 signed; DIV/REM: both signed.
   assign a_signed  = is_mul ? (bus.op_in[1:0] != 2'b11) : (is_div & ~bus.op_in[0]);
   assign b_signed  = is_mul ? ~bus.op_in[1]             : (is_div & ~bus.op_in[0]);
   assign sa        = a_signed & s1[XLEN-1];
   assign sb        = b_signed & s2[XLEN-1];
   assign mag_a     = sa ? -s1 : s1;
   assign mag_b     = sb ? -s2 : s2;
   assign take_hi_w = is_mul ? (bus.op_in[1:0] != 2'b00) : bus.op_in[1];
   // Remainder takes the dividend's sign; everything else the product sign.
   assign neg_w     = (is_div & bus.op_in[1]) ? sa : (sa ^ sb);
   assign div_zero  = (s2 == '0);
   assign div_ovf   = a_signed & (s1 == C_MIN) & (s2 == C_ONES);
   assign div_quick = div_zero ? (take_hi_w ? s1 : C_ONES)
                               : (take_hi_w ? '0 : s1);

`ifdef RV_ALU_MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
   // Low 2*XLEN bits of a sign-extended product are exact for every variant.
   assign ext_a      = {{XLEN{sa}}, s1};
   assign ext_b      = {{XLEN{sb}}, s2};
   assign fast_prod  = ext_a * ext_b;
   assign start_iter = is_div & ~div_zero & ~div_ovf;
   assign quick_res  = is_div ? div_quick
                     : is_mul ? (take_hi_w ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0])
                     : alu_res;
`else
   assign start_iter = is_mul | (is_div & ~div_zero & ~div_ovf);
   assign quick_res  = is_div ? div_quick : alu_res;
`endif

   // ---------------- iterative step datapath ----------------
   logic [XLEN:0]     mul_sum, div_trial;
   logic [XLEN-1:0]   mul_hi_n, mul_lo_n, rem_n, quot_n, div_sel, div_res, mul_res;
   logic [2*XLEN-1:0] mul_prod_n, mul_fix;
   logic              div_ge;

   assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
   assign mul_hi_n   = mul_sum[XLEN:1];
   assign mul_lo_n   = {mul_sum[0], acc_lo[XLEN-1:1]};
   assign mul_prod_n = {mul_hi_n, mul_lo_n};
   assign mul_fix    = neg_res ? -mul_prod_n : mul_prod_n;
   assign mul_res    = take_hi ? mul_fix[2*XLEN-1:XLEN] : mul_fix[XLEN-1:0];

   // Partial remainder is always below the divisor, so the shifted value
   // fits XLEN+1 bits and the trial's top bit is a clean borrow flag.
   assign div_trial  = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opnd_b};
   assign div_ge     = ~div_trial[XLEN];
   assign rem_n      = div_ge ? div_trial[XLEN-1:0] : {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
   assign quot_n     = {acc_lo[XLEN-2:0], div_ge};
   assign div_sel    = take_hi ? rem_n : quot_n;
   assign div_res    = neg_res ? -div_sel : div_sel;

   // ---------------- control ----------------
   logic in_ready_w, accept;
   assign in_ready_w = ~bus.flush_in &
                       ((state == S_IDLE) | ((state == S_DONE) & bus.out_ready));
   assign accept     = bus.in_valid & in_ready_w;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         count       <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         opnd_b      <= '0;
         result_r    <= '0;
         neg_res     <= 1'b0;
         take_hi     <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else if (bus.flush_in) begin
         state       <= S_IDLE;
         count       <= '0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  if (start_iter) begin
                     acc_hi      <= '0;
                     acc_lo      <= mag_a;
                     opnd_b      <= mag_b;
                     neg_res     <= neg_w;
                     take_hi     <= take_hi_w;
                     count       <= C_ITER;
                     busy_r      <= 1'b1;
                     out_valid_r <= 1'b0;
                     state       <= is_div ? S_DIV : S_MUL;
                  end else begin
                     result_r    <= quick_res;
                     out_valid_r <= 1'b1;
                     state       <= S_DONE;
                  end
               end else if ((state == S_DONE) && bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            S_MUL, S_DIV: begin
               acc_hi <= (state == S_MUL) ? mul_hi_n : rem_n;
               acc_lo <= (state == S_MUL) ? mul_lo_n : quot_n;
               count  <= count - C_LAST;
               if (count == C_LAST) begin
                  result_r    <= (state == S_MUL) ? mul_res : div_res;
                  out_valid_r <= 1'b1;
                  busy_r      <= 1'b0;
                  state       <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready   = in_ready_w;
   assign bus.out_valid  = out_valid_r;
   assign bus.result_out = result_r;
   assign bus.busy_out   = busy_r;
endmodule
`default_nettype wire

// File: tb/tb_rv_alu_mdu.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_rv_alu_mdu
// Purpose  : Self-checking bench for rv_alu_mdu (XLEN=32). Expected results
//            come from a behavioural reference model and are queued when an
//            op is accepted; a monitor pops and compares on each delivered
//            result. Latency, busy, backpressure, flush and reset are checked
//            directly. Honours RV_ALU_MDU_FAST_MUL_EN for MUL timing.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rv_alu_mdu;
   localparam int XLEN = 32;
`ifdef RV_ALU_MDU_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   rv_alu_mdu_if #(.XLEN(XLEN)) bus ();
   rv_alu_mdu #(.XLEN(XLEN)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] sb_q[$];
   logic [31:0] mon_exp;
   logic [31:0] last_res = '0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [4:0] op, input logic sub,
                                          input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] as, bs;
      logic signed [63:0] pa, pb, pp;
      logic [31:0]        r;
      as = a;
      bs = b;
      pa = {{32{a[31]}}, a};
      pb = {{32{b[31]}}, b};
      r  = '0;
      case (op)
         5'd0:  r = sub ? a - b : a + b;
         5'd1:  r = a ^ b;
         5'd2:  r = a | b;
         5'd3:  r = a & b;
         5'd4:  r = a << b[4:0];
         5'd5:  r = sub ? 32'(as >>> b[4:0]) : a >> b[4:0];
         5'd6:  r = {31'd0, as < bs};
         5'd7:  r = {31'd0, a < b};
         5'd8:  r = a + 32'd4;
         5'd9:  r = b;
         5'd16: begin pp = pa * pb;                  r = pp[31:0];  end
         5'd17: begin pp = pa * pb;                  r = pp[63:32]; end
         5'd18: begin pp = pa * $signed({32'd0, b}); r = pp[63:32]; end
         5'd19: begin pp = {32'd0, a} * {32'd0, b};  r = pp[63:32]; end
         5'd20: r = (b == 0) ? 32'hFFFF_FFFF :
                    (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(as / bs);
         5'd21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd22: r = (b == 0) ? a :
                    (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(as % bs);
         5'd23: r = (b == 0) ? a : a % b;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Scoreboard monitor: every delivered result must match the queue head.
   always @(negedge clk) begin
      if (reset_n && bus.out_valid && bus.out_ready) begin
         check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            mon_exp  = sb_q.pop_front();
            last_res = mon_exp;
            check_val("result", 64'(bus.result_out), 64'(mon_exp));
         end
      end
   end

   task automatic drive(input logic [4:0] op, input logic sub, input logic sel1,
                        input logic sel2, input logic [31:0] a, input logic [31:0] b);
      bus.op_in        = op;
      bus.sub_sra_in   = sub;
      bus.src1_in      = sel1;
      bus.src2_in      = sel2;
      bus.pc_in        = sel1 ? a : $urandom;
      bus.rs1_value_in = sel1 ? $urandom : a;
      bus.imm_in       = sel2 ? b : $urandom;
      bus.rs2_value_in = sel2 ? $urandom : b;
      bus.in_valid     = 1'b1;
   endtask

   // Called just after a posedge with in_valid high; returns at the accepting edge.
   task automatic wait_accept();
      int k;
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.in_ready) break;
      end
      check_val("accept_timeout", 64'(k < 50), 64'd1);
      @(posedge clk);
   endtask

   task automatic run_op(input logic [4:0] op, input logic sub, input logic sel1, input logic sel2,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int   lat;
      int   bsy;
      logic iter;
      iter = (op[4:2] == 3'b100 && !FAST) ||
             (op[4:2] == 3'b101 && b != 0 &&
              !(op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      @(posedge clk);
      #1;
      drive(op, sub, sel1, sel2, a, b);
      wait_accept();
      sb_q.push_back(exp);
      #1 bus.in_valid = 1'b0;
      lat = 0;
      bsy = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (bus.busy_out) bsy++;
         if (bus.out_valid) break;
      end
      check_val("latency",     64'(lat), iter ? 64'd33 : 64'd1);
      check_val("busy_cycles", 64'(bsy), iter ? 64'd32 : 64'd0);
   endtask

   logic [4:0] ops [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                            5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                            5'd12, 5'd31};
   logic [31:0] corners [4] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  op;
      logic        sub;
      logic [31:0] a, b;

      bus.flush_in = 1'b0;   bus.in_valid = 1'b0;  bus.op_in = '0;
      bus.sub_sra_in = 1'b0; bus.src1_in = 1'b0;   bus.src2_in = 1'b0;
      bus.pc_in = '0;        bus.rs1_value_in = '0; bus.rs2_value_in = '0;
      bus.imm_in = '0;       bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_out_valid", 64'(bus.out_valid),  64'd0);
      check_val("rst_result",    64'(bus.result_out), 64'd0);
      check_val("rst_busy",      64'(bus.busy_out),   64'd0);
      check_val("rst_in_ready",  64'(bus.in_ready),   64'd1);
      @(posedge clk);
      #2 reset_n = 1'b1;

      // SUB 5-7 then back-to-back SLTU 5,7
      @(posedge clk);
      #1 drive(5'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7);
      wait_accept();
      sb_q.push_back(32'hFFFF_FFFE);
      #1 drive(5'd7, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7);
      @(negedge clk);
      check_val("b2b_out_valid", 64'(bus.out_valid), 64'd1);
      check_val("b2b_in_ready",  64'(bus.in_ready),  64'd1);
      @(posedge clk);
      sb_q.push_back(32'd1);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check_val("b2b_sltu_valid", 64'(bus.out_valid), 64'd1);

      // Directed M-extension cases
      run_op(5'd17, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run_op(5'd20, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_op(5'd22, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_op(5'd21, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
      run_op(5'd23, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'd0, 32'h0000_1234);
      run_op(5'd20, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_op(5'd22, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

      // pc / immediate operand selection
      run_op(5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_1004);
      run_op(5'd9, 1'b0, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      run_op(5'd0, 1'b0, 1'b1, 1'b1, 32'h0000_2000, 32'hFFFF_FFF0, 32'h0000_1FF0);

      // Random mix against the reference model
      for (int i = 0; i < 30; i++) begin
         op  = ops[$urandom_range(0, 19)];
         sub = 1'($urandom);
         a   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
         b   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
         run_op(op, sub, 1'b0, 1'b0, a, b, ref_op(op, sub, a, b));
      end

      // Backpressure: XOR result held while out_ready is low
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      drive(5'd1, 1'b0, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h0FF0_1234);
      wait_accept();
      sb_q.push_back(32'hAA55_1D3B);
      #1 drive(5'd3, 1'b0, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h3C3C_3C3C);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val("bp_out_valid", 64'(bus.out_valid),  64'd1);
         check_val("bp_result",    64'(bus.result_out), 64'hAA55_1D3B);
         check_val("bp_in_ready",  64'(bus.in_ready),   64'd0);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      check_val("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      sb_q.push_back(32'h3030_3030);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check_val("bp_and_valid", 64'(bus.out_valid), 64'd1);

      // Flush 10 cycles into a DIVU with another op presented
      @(posedge clk);
      #1 drive(5'd21, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
      wait_accept();
      #1 drive(5'd1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
      repeat (9) @(posedge clk);
      #1 bus.flush_in = 1'b1;
      @(negedge clk);
      check_val("flush_in_ready", 64'(bus.in_ready), 64'd0);
      check_val("flush_pre_busy", 64'(bus.busy_out), 64'd1);
      @(posedge clk);
      #1 bus.flush_in = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_val("flush_out_valid", 64'(bus.out_valid),  64'd0);
      check_val("flush_busy",      64'(bus.busy_out),   64'd0);
      check_val("flush_idle",      64'(bus.in_ready),   64'd1);
      check_val("flush_result",    64'(bus.result_out), 64'(last_res));
      @(negedge clk);
      check_val("flush_no_accept", 64'(bus.out_valid),  64'd0);

      // Async reset in the middle of an iterative op
      @(posedge clk);
      #1 drive(FAST ? 5'd21 : 5'd16, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      wait_accept();
      #1 bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_val("arst_out_valid", 64'(bus.out_valid),  64'd0);
      check_val("arst_result",    64'(bus.result_out), 64'd0);
      check_val("arst_busy",      64'(bus.busy_out),   64'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check_val("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_val("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
